// File: rtl/rtc_bus_responder.sv
// rtl/rtc_bus_responder.sv - RTC multiplexed address/data bus responder with local register file
module rtc_bus_responder #(
   parameter int DEPTH    = 16,
   parameter int HOLD_CYC = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_d,
   input  logic       cs,
   input  logic       rd,
   input  logic       wr,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   input  logic       upd_en,
   input  logic [7:0] upd_addr,
   input  logic [7:0] upd_data,
   input  logic       err_clr,
   output logic       reg_wr_stb,
   output logic [7:0] reg_wr_addr,
   output logic       proto_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_AWAIT, ST_WRITE, ST_READ, ST_HOLD, ST_ERRW
   } state_t;

   state_t     state_q, state_d;
   logic       s_a_d_q, s_cs_q, s_rd_q, s_wr_q;
   logic [7:0] s_ad_in_q;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] ad_out_q, ad_out_d;
   logic       ad_oe_q, ad_oe_d;
   logic [7:0] cnt_q, cnt_d;
   logic       reg_wr_stb_q;
   logic [7:0] reg_wr_addr_q;
   logic       proto_err_q;
   logic [7:0] regs_q [DEPTH];

   logic       as_s, ws_s, rs_s, cs_bad_s;
   logic       commit, err_set;
   logic       addr_in_range, upd_in_range;
   logic [7:0] rd_data;

   assign as_s     = !s_cs_q & !s_a_d_q & !s_wr_q;
   assign ws_s     = !s_cs_q &  s_a_d_q & !s_wr_q &  s_rd_q;
   assign rs_s     = !s_cs_q &  s_a_d_q & !s_rd_q &  s_wr_q;
   assign cs_bad_s = !s_cs_q &  s_a_d_q & !s_rd_q & !s_wr_q;

   assign addr_in_range = ({1'b0, addr_q} < 9'(DEPTH));
   assign upd_in_range  = ({1'b0, upd_addr} < 9'(DEPTH));
   assign rd_data       = addr_in_range ? regs_q[addr_q[AW-1:0]] : 8'h00;

   // Single-stage capture of the bus pins; idle values keep the FSM quiet out of reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_a_d_q   <= 1'b0;
         s_cs_q    <= 1'b1;
         s_rd_q    <= 1'b1;
         s_wr_q    <= 1'b1;
         s_ad_in_q <= 8'h00;
      end else begin
         s_a_d_q   <= a_d;
         s_cs_q    <= cs;
         s_rd_q    <= rd;
         s_wr_q    <= wr;
         s_ad_in_q <= ad_in;
      end
   end

   // Transfer FSM: next state, address/data capture, read drive and commit/error decisions
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ad_out_d = ad_out_q;
      ad_oe_d  = ad_oe_q;
      cnt_d    = cnt_q;
      commit   = 1'b0;
      err_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (as_s) begin
               state_d = ST_ADDR;
               addr_d  = s_ad_in_q;
            end else if (ws_s || rs_s || cs_bad_s) begin
               err_set = 1'b1;
               state_d = ST_ERRW;
            end
         end
         ST_ADDR: begin
            if (as_s) addr_d = s_ad_in_q;
            else      state_d = ST_AWAIT;
         end
         ST_AWAIT: begin
            if (as_s) begin
               state_d = ST_ADDR;
               addr_d  = s_ad_in_q;
            end else if (ws_s) begin
               state_d = ST_WRITE;
               wdata_d = s_ad_in_q;
            end else if (rs_s) begin
               state_d  = ST_READ;
               ad_oe_d  = 1'b1;
               ad_out_d = rd_data;
            end else if (cs_bad_s) begin
               err_set = 1'b1;
               state_d = ST_ERRW;
            end
         end
         ST_WRITE: begin
            // A read strobe during a write aborts it; the data is never committed
            if (!s_rd_q) begin
               err_set = 1'b1;
               state_d = ST_ERRW;
            end else if (ws_s) begin
               wdata_d = s_ad_in_q;
            end else begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (!rs_s) begin
               state_d = ST_HOLD;
               cnt_d   = 8'h00;
            end
         end
         ST_HOLD: begin
            if (as_s) begin
               state_d = ST_ADDR;
               addr_d  = s_ad_in_q;
               ad_oe_d = 1'b0;
            end else if (cnt_q == 8'(HOLD_CYC - 1)) begin
               state_d = ST_IDLE;
               ad_oe_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'h01;
            end
         end
         ST_ERRW: begin
            if (s_cs_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, datapath and status registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         addr_q        <= 8'h00;
         wdata_q       <= 8'h00;
         ad_out_q      <= 8'h00;
         ad_oe_q       <= 1'b0;
         cnt_q         <= 8'h00;
         reg_wr_stb_q  <= 1'b0;
         reg_wr_addr_q <= 8'h00;
         proto_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ad_out_q     <= ad_out_d;
         ad_oe_q      <= ad_oe_d;
         cnt_q        <= cnt_d;
         reg_wr_stb_q <= commit;
         if (commit) reg_wr_addr_q <= addr_q;
         if (err_set)      proto_err_q <= 1'b1;
         else if (err_clr) proto_err_q <= 1'b0;
      end
   end

   // Register file: bus commit takes priority over the local update port on the same entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (commit && addr_in_range && (addr_q[AW-1:0] == AW'(i)))
               regs_q[i] <= wdata_q;
            else if (upd_en && upd_in_range && (upd_addr[AW-1:0] == AW'(i)))
               regs_q[i] <= upd_data;
         end
      end
   end

   assign ad_out      = ad_out_q;
   assign ad_oe       = ad_oe_q;
   assign reg_wr_stb  = reg_wr_stb_q;
   assign reg_wr_addr = reg_wr_addr_q;
   assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb/tb_rtc_bus_responder.sv - self-checking bench for rtc_bus_responder
module tb_rtc_bus_responder;

   localparam int DEPTH    = 16;
   localparam int HOLD_CYC = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_d, cs, rd, wr;
   logic [7:0] ad_in;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic       upd_en;
   logic [7:0] upd_addr, upd_data;
   logic       err_clr;
   logic       reg_wr_stb;
   logic [7:0] reg_wr_addr;
   logic       proto_err;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] m_regs [DEPTH];

   rtc_bus_responder #(.DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC)) dut (
      .clk(clk), .reset(reset), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
      .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
      .upd_en(upd_en), .upd_addr(upd_addr), .upd_data(upd_data),
      .err_clr(err_clr), .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr),
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] model_read(input logic [7:0] a);
      return (int'(a) < DEPTH) ? m_regs[a[3:0]] : 8'h00;
   endfunction

   function automatic logic [31:0] exp_oe(input int n);
      logic [31:0] m = '0;
      for (int k = 1; k <= n + HOLD_CYC; k++) m[k] = 1'b1;
      return m;
   endfunction

   task automatic bus_idle();
      cs = 1'b1; rd = 1'b1; wr = 1'b1; a_d = 1'b0;
   endtask

   task automatic addr_phase(input logic [7:0] a, input int n, input int gap);
      cs = 1'b0; a_d = 1'b0; wr = 1'b0; rd = 1'b1; ad_in = a;
      repeat (n) @(negedge clk);
      bus_idle();
      ad_in = 8'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   task automatic bus_write(input logic [7:0] d, input int n, input bit do_upd,
                            input logic [7:0] ua, input logic [7:0] ud,
                            output logic [15:0] stb_bits, output logic [7:0] stb_addr);
      cs = 1'b0; a_d = 1'b1; wr = 1'b0; rd = 1'b1; ad_in = d;
      repeat (n) @(negedge clk);
      bus_idle();
      ad_in = 8'($urandom);
      stb_bits = '0;
      stb_addr = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         stb_bits[k] = reg_wr_stb;
         if (reg_wr_stb) stb_addr = reg_wr_addr;
         if (do_upd && k == 0) begin
            upd_en = 1'b1; upd_addr = ua; upd_data = ud;
         end else begin
            upd_en = 1'b0;
         end
      end
   endtask

   task automatic bus_read(input int n, output logic [31:0] oe_bits,
                           output logic [7:0] dout, output bit stable);
      bit seen = 0;
      cs = 1'b0; a_d = 1'b1; rd = 1'b0; wr = 1'b1;
      oe_bits = '0; dout = 8'h00; stable = 1'b1;
      for (int k = 0; k < n + HOLD_CYC + 3; k++) begin
         if (k == n) bus_idle();
         @(negedge clk);
         oe_bits[k] = ad_oe;
         if (ad_oe) begin
            if (!seen) begin dout = ad_out; seen = 1; end
            else if (ad_out !== dout) stable = 1'b0;
         end
      end
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_idle(); ad_in = 8'h00; upd_en = 1'b0; upd_addr = 8'h00; upd_data = 8'h00; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
      tests_run++; if (ad_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_ad_oe: got %b expected 0", ad_oe); end
      tests_run++; if (ad_out !== 8'h00) begin tests_failed++; $display("FAIL reset_ad_out: got %h expected 00", ad_out); end
      tests_run++; if (reg_wr_stb !== 1'b0) begin tests_failed++; $display("FAIL reset_stb: got %b expected 0", reg_wr_stb); end
      tests_run++; if (reg_wr_addr !== 8'h00) begin tests_failed++; $display("FAIL reset_wr_addr: got %h expected 00", reg_wr_addr); end
      tests_run++; if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write();
      logic [15:0] sb; logic [7:0] sa;
      addr_phase(8'h03, 8, 2);
      bus_write(8'h5A, 8, 0, 8'h00, 8'h00, sb, sa);
      m_regs[3] = 8'h5A;
      tests_run++; if (sb !== 16'h0002) begin tests_failed++; $display("FAIL write_stb_timing: got %h expected 0002", sb); end
      tests_run++; if (sa !== 8'h03) begin tests_failed++; $display("FAIL write_stb_addr: got %h expected 03", sa); end
   endtask

   task automatic test_readback();
      logic [31:0] ob; logic [7:0] d; bit st;
      addr_phase(8'h03, 4, 2);
      bus_read(6, ob, d, st);
      tests_run++; if (ob !== exp_oe(6)) begin tests_failed++; $display("FAIL readback_oe_window: got %h expected %h", ob, exp_oe(6)); end
      tests_run++; if (d !== model_read(8'h03)) begin tests_failed++; $display("FAIL readback_data: got %h expected %h", d, model_read(8'h03)); end
      tests_run++; if (st !== 1'b1) begin tests_failed++; $display("FAIL readback_stable: got %b expected 1", st); end
   endtask

   task automatic test_out_of_range();
      logic [15:0] sb; logic [7:0] sa; logic [31:0] ob; logic [7:0] d; bit st;
      addr_phase(8'h20, 3, 1);
      bus_write(8'h77, 3, 0, 8'h00, 8'h00, sb, sa);
      tests_run++; if (sb !== 16'h0002) begin tests_failed++; $display("FAIL oor_stb_timing: got %h expected 0002", sb); end
      tests_run++; if (sa !== 8'h20) begin tests_failed++; $display("FAIL oor_stb_addr: got %h expected 20", sa); end
      addr_phase(8'h20, 3, 1);
      bus_read(3, ob, d, st);
      tests_run++; if (ob !== exp_oe(3)) begin tests_failed++; $display("FAIL oor_read_oe: got %h expected %h", ob, exp_oe(3)); end
      tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL oor_read_data: got %h expected 00", d); end
      addr_phase(8'h00, 3, 1);
      bus_read(3, ob, d, st);
      tests_run++; if (d !== model_read(8'h00)) begin tests_failed++; $display("FAIL oor_alias_reg0: got %h expected %h", d, model_read(8'h00)); end
   endtask

   task automatic test_proto_err();
      logic [15:0] sb; logic [7:0] sa; logic [7:0] oe_seen;
      bus_write(8'h99, 3, 0, 8'h00, 8'h00, sb, sa);
      tests_run++; if (sb !== 16'h0000) begin tests_failed++; $display("FAIL noaddr_commit: got %h expected 0000", sb); end
      tests_run++; if (proto_err !== 1'b1) begin tests_failed++; $display("FAIL noaddr_proto_err: got %b expected 1", proto_err); end
      pulse_err_clr();
      tests_run++; if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL err_clr: got %b expected 0", proto_err); end
      addr_phase(8'h05, 3, 1);
      cs = 1'b0; a_d = 1'b1; rd = 1'b0; wr = 1'b0;
      oe_seen = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         oe_seen[k] = ad_oe;
      end
      bus_idle();
      repeat (3) @(negedge clk);
      tests_run++; if (oe_seen !== 8'h00) begin tests_failed++; $display("FAIL rdwr_both_oe: got %h expected 00", oe_seen); end
      tests_run++; if (proto_err !== 1'b1) begin tests_failed++; $display("FAIL rdwr_both_proto_err: got %b expected 1", proto_err); end
      pulse_err_clr();
      tests_run++; if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL err_clr2: got %b expected 0", proto_err); end
   endtask

   task automatic test_update_collision();
      logic [15:0] sb; logic [7:0] sa; logic [31:0] ob; logic [7:0] d; bit st;
      addr_phase(8'h03, 3, 1);
      bus_write(8'hA5, 3, 1, 8'h03, 8'h11, sb, sa);
      m_regs[3] = 8'h11;
      m_regs[3] = 8'hA5;
      addr_phase(8'h03, 2, 1);
      bus_read(3, ob, d, st);
      tests_run++; if (d !== model_read(8'h03)) begin tests_failed++; $display("FAIL collide_same: got %h expected %h", d, model_read(8'h03)); end
      addr_phase(8'h03, 3, 1);
      bus_write(8'h5C, 3, 1, 8'h04, 8'h22, sb, sa);
      m_regs[4] = 8'h22;
      m_regs[3] = 8'h5C;
      addr_phase(8'h03, 2, 1);
      bus_read(3, ob, d, st);
      tests_run++; if (d !== model_read(8'h03)) begin tests_failed++; $display("FAIL collide_diff_bus: got %h expected %h", d, model_read(8'h03)); end
      addr_phase(8'h04, 2, 1);
      bus_read(3, ob, d, st);
      tests_run++; if (d !== model_read(8'h04)) begin tests_failed++; $display("FAIL collide_diff_upd: got %h expected %h", d, model_read(8'h04)); end
   endtask

   task automatic test_random();
      logic [15:0] sb; logic [7:0] sa; logic [31:0] ob; logic [7:0] d; bit st;
      logic [7:0] a, v, ua, ud;
      int op, n; bit du;
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 3);
         a  = 8'($urandom_range(0, 31));
         v  = 8'($urandom);
         n  = $urandom_range(2, 5);
         if (op == 3) begin
            @(negedge clk);
            upd_en = 1'b1; upd_addr = a; upd_data = v;
            @(negedge clk);
            upd_en = 1'b0;
            if (int'(a) < DEPTH) m_regs[a[3:0]] = v;
         end else begin
            if ($urandom_range(0, 3) == 0) addr_phase(8'($urandom), $urandom_range(2, 4), 1);
            addr_phase(a, $urandom_range(2, 5), $urandom_range(1, 3));
            if (op == 2) begin
               bus_read(n, ob, d, st);
               tests_run++; if (ob !== exp_oe(n)) begin tests_failed++; $display("FAIL rand_read_oe it=%0d: got %h expected %h", it, ob, exp_oe(n)); end
               tests_run++; if (d !== model_read(a)) begin tests_failed++; $display("FAIL rand_read_data it=%0d addr=%h: got %h expected %h", it, a, d, model_read(a)); end
               tests_run++; if (st !== 1'b1) begin tests_failed++; $display("FAIL rand_read_stable it=%0d: got %b expected 1", it, st); end
            end else begin
               du = 1'($urandom_range(0, 1));
               ua = 8'($urandom_range(0, 31));
               ud = 8'($urandom);
               bus_write(v, n, du, ua, ud, sb, sa);
               if (du && int'(ua) < DEPTH) m_regs[ua[3:0]] = ud;
               if (int'(a) < DEPTH) m_regs[a[3:0]] = v;
               tests_run++; if (sb !== 16'h0002) begin tests_failed++; $display("FAIL rand_write_stb it=%0d: got %h expected 0002", it, sb); end
               tests_run++; if (sa !== a) begin tests_failed++; $display("FAIL rand_write_addr it=%0d: got %h expected %h", it, sa, a); end
            end
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         addr_phase(8'(i), 2, 1);
         bus_read(2, ob, d, st);
         tests_run++; if (d !== m_regs[i]) begin tests_failed++; $display("FAIL rand_final_reg%0d: got %h expected %h", i, d, m_regs[i]); end
      end
   endtask

   task automatic test_reset_mid_read();
      logic [15:0] sb; logic [7:0] sa; logic [31:0] ob; logic [7:0] d; bit st;
      addr_phase(8'h03, 2, 1);
      cs = 1'b0; a_d = 1'b1; rd = 1'b0; wr = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++; if (ad_oe !== 1'b1) begin tests_failed++; $display("FAIL midread_pre_oe: got %b expected 1", ad_oe); end
      reset = 1'b1;
      #1;
      tests_run++; if (ad_oe !== 1'b0) begin tests_failed++; $display("FAIL midread_reset_oe: got %b expected 0", ad_oe); end
      @(negedge clk);
      bus_idle();
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
      repeat (2) @(negedge clk);
      bus_write(8'h33, 3, 0, 8'h00, 8'h00, sb, sa);
      tests_run++; if (proto_err !== 1'b1) begin tests_failed++; $display("FAIL midread_noaddr_err: got %b expected 1", proto_err); end
      tests_run++; if (sb !== 16'h0000) begin tests_failed++; $display("FAIL midread_noaddr_commit: got %h expected 0000", sb); end
      pulse_err_clr();
      addr_phase(8'h03, 2, 1);
      bus_read(3, ob, d, st);
      tests_run++; if (d !== model_read(8'h03)) begin tests_failed++; $display("FAIL midread_regs_cleared: got %h expected %h", d, model_read(8'h03)); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_readback();
      test_out_of_range();
      test_proto_err();
      test_update_collision();
      test_random();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Bus-side responder for the RTC multiplexed address/data interface. It decodes `a_d`/`cs`/`rd`/`wr` strobes from the write/read initiator FSM, latches the address, and commits write data into a local register file. On reads it drives register contents back onto the data bus. It serves as the RTC emulator for FPGA bring-up and as the slave model in initiator testbenches; an internal update port lets local timekeeping logic refresh registers.

## Interface
- `DEPTH`, 16: number of 8-bit registers; power of two, 2..256.
- `HOLD_CYC`, 4: cycles `ad_oe` remains asserted after the read strobe is released.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `a_d` in 1: 0 = address phase, 1 = data phase.
- `cs` in 1: chip select, active low.
- `rd` in 1: read strobe, active low. Only a driven 0 counts as asserted; a released line is pulled up on the board.
- `wr` in 1: write/address strobe, active low.
- `ad_in` in 8: bus value from the pads.
- `ad_out` out 8: data driven to the bus during reads.
- `ad_oe` out 1: pad output enable for `ad_out`.
- `upd_en` in 1: local register write enable.
- `upd_addr` in 8: local write address.
- `upd_data` in 8: local write data.
- `err_clr` in 1: clears `proto_err`.
- `reg_wr_stb` out 1: one-cycle pulse when a bus write commits.
- `reg_wr_addr` out 8: address of the committed bus write.
- `proto_err` out 1: sticky protocol-error flag.

## Operation
- **Input sampling.** `a_d`, `cs`, `rd`, `wr` and `ad_in` are registered once into `s_*`. The FSM and all decoding act only on the `s_*` copies.
- **Derived strobes:**
  - AS = `!s_cs & !s_a_d & !s_wr`
  - WS = `!s_cs & s_a_d & !s_wr & s_rd`
  - RS = `!s_cs & s_a_d & !s_rd & s_wr`
  - CS_BAD = `!s_cs & s_a_d & !s_rd & !s_wr`
- **States:** IDLE, ADDR, AWAIT, WRITE, READ, HOLD, ERRW.
- **IDLE:**
  - AS goes to ADDR.
  - WS, RS or CS_BAD sets `proto_err` (no valid address) and goes to ERRW.
- **ADDR:** captures `s_ad_in` into `addr` on every cycle. When AS drops, goes to AWAIT with the address valid.
- **AWAIT:**
  - AS goes to ADDR (re-addressing is legal; the last address wins).
  - WS goes to WRITE.
  - RS goes to READ.
  - CS_BAD sets `proto_err` and goes to ERRW.
- **WRITE:** captures `s_ad_in` into `wdata` on every cycle.
  - When WS drops, commits `wdata` to `regs[addr]` if `addr < DEPTH`, pulses `reg_wr_stb`, and goes to IDLE.
  - If `rd` becomes asserted while in WRITE, sets `proto_err`, skips the commit, and goes to ERRW.
- **READ:** `ad_out` = `regs[addr]`, or 0x00 if `addr >= DEPTH`; `ad_oe` = 1. When RS drops, goes to HOLD.
- **HOLD:** keeps `ad_out`/`ad_oe` for `HOLD_CYC` cycles, then goes to IDLE. AS in HOLD drops `ad_oe` on the same edge and goes to ADDR.
- **ERRW:** waits until `s_cs` = 1, then goes to IDLE.
- **Address validity.** Each address phase serves exactly one data phase; the address is consumed on exit from WRITE, HOLD or ERRW.
- **Update port:**
  - `upd_en` writes `upd_data` to `regs[upd_addr]` when `upd_addr < DEPTH`; out-of-range addresses are ignored.
  - A bus commit and `upd_en` to the same address on the same edge: the bus write wins.
  - Different addresses on the same edge: both writes happen.
- **`err_clr`.** Clears `proto_err`. If a new error is detected on the same edge, set wins.
- **Reset values:** state IDLE; `regs`, `addr`, `wdata`, `ad_out` all 0x00; `ad_oe`, `reg_wr_stb`, `reg_wr_addr`, `proto_err` all 0. Reset mid-transfer drops `ad_oe` immediately, discards pending writes, and invalidates the address.

## Timing
- **Input latency:** one cycle from pin to `s_*`.
- **Read drive:** `ad_out`/`ad_oe` are registered and update on the edge the FSM enters READ. This is the 2nd rising edge after `rd` first reads 0 at the pin.
- **Read data sample:** `ad_out` reflects `regs` as of the READ-entry edge. An update landing during READ is not reflected until the next read.
- **Read release:** `ad_oe` falls `HOLD_CYC` + 1 edges after the first sampled `rd` = 1.
- **Write commit:** `reg_wr_stb` is high for exactly one cycle, starting at the 2nd edge after `wr` rises at the pin. `reg_wr_addr` is valid in that cycle. The register is readable from the next cycle.
- **Minimum pulse widths:** strobes of ≥2 cycles are handled; 1-cycle strobes are not guaranteed.

## Test plan
- **Write:** address phase 0x03 for 8 cycles, 2-cycle gap, write 0x5A for 8 cycles -> `reg_wr_stb` pulses once with `reg_wr_addr` = 0x03, and `regs[3]` = 0x5A.
- **Read-back:** read 0x03 after the write -> `ad_oe` high from the 2nd edge after `rd` falls until 5 edges after `rd` rises; `ad_out` = 0x5A for that whole window.
- **Out-of-range access:** write 0x77 to address 0x20 (`DEPTH` = 16), then read 0x20 -> no register changes, `reg_wr_stb` still pulses, read returns 0x00.
- **Protocol errors:**
  - Data-phase write with no prior address -> `proto_err` = 1, no commit.
  - `rd` and `wr` both low in the data phase -> `proto_err` = 1, `ad_oe` stays 0.
  - `err_clr` -> `proto_err` = 0.
- **Update collision:** `upd_en` to 0x03 = 0x11 on the same edge as a bus commit of 0xA5 -> `regs[3]` = 0xA5. Repeat with `upd_addr` = 0x04 -> both registers written.
- **Reset mid-read:** assert `reset` during READ -> `ad_oe` = 0 immediately. A following data phase without a new address sets `proto_err`.
